// File: rtl/communication_send_param_pkg.sv
// Shared definitions for the parametrised serial frame transmitter:
// parity modes, FSM state encoding and a width helper for counters.
package communication_send_param_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_t;

  // Ceiling log2, never less than 1 so every counter has at least one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/communication_send_param_send.sv
// Input FIFO for the frame transmitter. Registered, no fall-through: a word
// written at an edge is visible at the read port only after that edge.
// The level is kept in its own register so full and empty never alias.
module send_fifo
  import communication_send_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2_min1(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level_nx;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    level_nx = level;
    case ({do_push, do_pop})
      2'b10:   level_nx = level + LVL_W'(1);
      2'b01:   level_nx = level - LVL_W'(1);
      default: level_nx = level;
    endcase
  end

  // Pointers, level and flags; flush empties the FIFO like a reset.
  always_ff @(posedge clk1) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nx;
      full  <= (level_nx == LVL_W'(DEPTH));
      empty <= (level_nx == '0);
    end
  end

  // Storage array; payload only, so it carries no reset.
  always_ff @(posedge clk1) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/communication_send_param.sv
// Parametrised serial frame transmitter: start bit, DATA_W data bits
// LSB-first, optional parity, STOP_BITS stop bits on line sd. Each bit lasts
// CLKS_PER_BIT clk1 cycles. Back-to-back frames are sent with no idle gap
// while the input FIFO holds words and send_en stays high.
module communication_send_param
  import communication_send_param_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 2,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4,
  localparam int LVL_W       = clog2_min1(FIFO_DEPTH) + 1
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              send_en,
  input  logic [DATA_W-1:0] send_data,
  input  logic              send_valid,
  output logic              send_ready,
  output logic              sd,
  output logic              busy,
  output logic              frame_done,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int CNT_W = clog2_min1(CLKS_PER_BIT);
  localparam int IDX_W = clog2_min1((DATA_W > STOP_BITS) ? DATA_W : STOP_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  idx_nx;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nx;
  logic              par_bit;
  logic              par_nx;
  logic              sd_nx;
  logic              busy_nx;
  logic              done_nx;
  logic              load;
  logic              bit_end;
  logic              ready_q;

  logic              pop;
  logic              push;
  logic              flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  // Even parity is the XOR of the word; odd parity is its complement.
  function automatic logic frame_parity(input logic [DATA_W-1:0] word);
    if (PARITY == PARITY_ODD) return ~^word;
    return ^word;
  endfunction

  assign bit_end    = (bit_cnt == CNT_LAST);
  assign flush      = !send_en;
  assign send_ready = ready_q && !fifo_full;
  // The end-of-frame pop frees a slot, so a push at that edge is kept.
  assign push       = send_valid && send_en && ready_q && (!fifo_full || pop);

  send_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk1  (clk1),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (send_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next state, counters, shift register and the registered-output values.
  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    idx_nx   = bit_idx;
    shift_nx = shift;
    par_nx   = par_bit;
    load     = 1'b0;

    case (state)
      S_IDLE: begin
        load = !fifo_empty;
      end
      S_START: begin
        if (bit_end) begin
          state_nx = S_DATA;
          cnt_nx   = '0;
          idx_nx   = '0;
        end else begin
          cnt_nx = bit_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_nx = '0;
          if (bit_idx == DATA_LAST) begin
            idx_nx   = '0;
            state_nx = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end else begin
            idx_nx   = bit_idx + IDX_W'(1);
            shift_nx = shift >> 1;
          end
        end else begin
          cnt_nx = bit_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nx = S_STOP;
          cnt_nx   = '0;
          idx_nx   = '0;
        end else begin
          cnt_nx = bit_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_nx = '0;
          if (bit_idx == STOP_LAST) begin
            idx_nx   = '0;
            state_nx = S_IDLE;
            load     = !fifo_empty;
          end else begin
            idx_nx = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_nx = bit_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase

    // Start a frame from the FIFO head, either from idle or straight after
    // the last stop bit so consecutive frames have no gap.
    if (load) begin
      state_nx = S_START;
      cnt_nx   = '0;
      idx_nx   = '0;
      shift_nx = fifo_rdata;
      par_nx   = frame_parity(fifo_rdata);
    end

    // Dropping send_en abandons the frame at this edge.
    if (!send_en) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
      load     = 1'b0;
    end

    pop = load;

    case (state_nx)
      S_START:  sd_nx = 1'b0;
      S_DATA:   sd_nx = shift_nx[0];
      S_PARITY: sd_nx = par_nx;
      default:  sd_nx = 1'b1;
    endcase
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_STOP) && (cnt_nx == CNT_LAST) && (idx_nx == STOP_LAST);
  end

  // Control state and registered line outputs.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      sd         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= cnt_nx;
      bit_idx    <= idx_nx;
      sd         <= sd_nx;
      busy       <= busy_nx;
      frame_done <= done_nx;
      ready_q    <= 1'b1;
    end
  end

  // Frame payload; only read while a frame is active, so it is not reset.
  always_ff @(posedge clk1) begin
    shift   <= shift_nx;
    par_bit <= par_nx;
  end

endmodule

// File: tb/tb_communication_send_param.sv
// Bench for communication_send_param: three configurations driven by shared
// stimulus, each compared every cycle against a frame-level reference model.
module tb_communication_send_param;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       send_en;
  logic       send_valid;
  logic [7:0] send_data;

  logic       rdy_o  [3];
  logic       sd_o   [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic [2:0] lvl0;
  logic [1:0] lvl1;
  logic [2:0] lvl2;

  localparam int CFG_PAR  [3] = '{1, 2, 0};
  localparam int CFG_STOP [3] = '{2, 1, 2};
  localparam int CFG_CPB  [3] = '{4, 3, 4};
  localparam int CFG_DEP  [3] = '{4, 2, 4};
  localparam int LIT_LEN  [3] = '{48, 33, 44};

  // start, 0xA5 LSB-first, even parity 0, two stop bits (bit 0 = start)
  logic [11:0] lit_a5 = 12'b1101_0100_1010;

  always #5 clk1 = ~clk1;

  communication_send_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut0 (
    .clk1(clk1), .rst(rst), .send_en(send_en), .send_data(send_data), .send_valid(send_valid),
    .send_ready(rdy_o[0]), .sd(sd_o[0]), .busy(busy_o[0]), .frame_done(done_o[0]), .fifo_level(lvl0));

  communication_send_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(3), .FIFO_DEPTH(2)) dut1 (
    .clk1(clk1), .rst(rst), .send_en(send_en), .send_data(send_data), .send_valid(send_valid),
    .send_ready(rdy_o[1]), .sd(sd_o[1]), .busy(busy_o[1]), .frame_done(done_o[1]), .fifo_level(lvl1));

  communication_send_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut2 (
    .clk1(clk1), .rst(rst), .send_en(send_en), .send_data(send_data), .send_valid(send_valid),
    .send_ready(rdy_o[2]), .sd(sd_o[2]), .busy(busy_o[2]), .frame_done(done_o[2]), .fifo_level(lvl2));

  // Reference model state
  int         m_cnt [3];
  logic [7:0] m_q   [3][4];
  bit         m_act [3];
  int         m_pos [3];
  logic [7:0] m_cur [3];
  bit         m_rdy [3];
  int         f_cnt [3];
  int         checks  = 0;
  int         errors  = 0;
  bit         started = 0;

  function automatic int frame_len(input int k);
    return (1 + 8 + ((CFG_PAR[k] != 0) ? 1 : 0) + CFG_STOP[k]) * CFG_CPB[k];
  endfunction

  // Line level for bit slot b of a frame carrying word w.
  function automatic int exp_bit(input int k, input logic [7:0] w, input int b);
    if (b == 0) return 0;
    if (b <= 8) return int'(w[b-1]);
    if (CFG_PAR[k] != 0 && b == 9) begin
      int ones;
      ones = $countones(w);
      if (CFG_PAR[k] == 1) return ones % 2;
      return 1 - (ones % 2);
    end
    return 1;
  endfunction

  function automatic int lvl_of(input int k);
    case (k)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      default: return int'(lvl2);
    endcase
  endfunction

  task automatic check(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s[cfg%0d] at %0t: got %0d, expected %0d", name, k, $time, act, exp);
    end
  endtask

  // Advance the model at each edge, then compare 1 time unit later.
  always @(posedge clk1) begin : compare
    bit         r, e, v, push_ok;
    logic [7:0] d;
    int         es, ed;
    r = rst; e = send_en; v = send_valid; d = send_data;
    if (!r) started = 1;
    for (int k = 0; k < 3; k++) begin
      if (!r) begin
        m_cnt[k] = 0; m_act[k] = 0; m_pos[k] = 0; m_rdy[k] = 0;
      end else if (!e) begin
        m_cnt[k] = 0; m_act[k] = 0; m_pos[k] = 0; m_rdy[k] = 1;
      end else begin
        push_ok = v && m_rdy[k];
        if (m_act[k]) begin
          m_pos[k]++;
          if (m_pos[k] == frame_len(k)) m_act[k] = 0;
        end
        if (!m_act[k] && m_cnt[k] > 0) begin
          m_cur[k] = m_q[k][0];
          for (int i = 0; i < 3; i++) m_q[k][i] = m_q[k][i+1];
          m_cnt[k]--;
          m_act[k] = 1;
          m_pos[k] = 0;
        end
        if (push_ok && m_cnt[k] < CFG_DEP[k]) begin
          m_q[k][m_cnt[k]] = d;
          m_cnt[k]++;
        end
        m_rdy[k] = 1;
      end
    end
    #1;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        es = m_act[k] ? exp_bit(k, m_cur[k], m_pos[k] / CFG_CPB[k]) : 1;
        ed = (m_act[k] && m_pos[k] == frame_len(k) - 1) ? 1 : 0;
        check("sd", k, int'(sd_o[k]), es);
        check("busy", k, int'(busy_o[k]), m_act[k] ? 1 : 0);
        check("frame_done", k, int'(done_o[k]), ed);
        check("fifo_level", k, lvl_of(k), m_cnt[k]);
        check("send_ready", k, int'(rdy_o[k]), (m_rdy[k] && m_cnt[k] < CFG_DEP[k]) ? 1 : 0);
        if (k == 0 && m_act[0] && m_cur[0] == 8'hA5)
          check("model_a5_pattern", k, es, int'(lit_a5[m_pos[0] / 4]));
        if (k < 2 && m_act[k] && m_cur[k] == 8'h07 && m_pos[k] / CFG_CPB[k] == 9)
          check("model_parity_07", k, es, (k == 0) ? 1 : 0);
        if (busy_o[k]) f_cnt[k]++;
        else f_cnt[k] = 0;
        if (done_o[k]) begin
          check("frame_length", k, f_cnt[k], LIT_LEN[k]);
          f_cnt[k] = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    send_valid = 1'b0;
    repeat (n) @(negedge clk1);
  endtask

  task automatic push(input logic [7:0] w);
    send_valid = 1'b1;
    send_data  = w;
    @(negedge clk1);
    send_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_act[k] = 0; m_pos[k] = 0; m_rdy[k] = 0; f_cnt[k] = 0; m_cur[k] = '0;
    end
    rst = 1'b0; send_en = 1'b1; send_valid = 1'b0; send_data = '0;
    repeat (3) @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);

    // single frames
    push(8'hA5);
    idle(60);
    push(8'h07);
    idle(60);

    // burst beyond FIFO depth
    for (int i = 1; i <= 6; i++) push(8'(i));
    idle(48 * 6 + 20);

    // abort during data bit 3 of the first frame with words queued
    push(8'h11);
    push(8'h22);
    push(8'h33);
    idle(15);
    send_en = 1'b0;
    @(negedge clk1);
    send_en = 1'b1;
    idle(2);
    push(8'h3C);
    idle(60);

    // reset during the parity bit
    push(8'h5A);
    idle(37);
    rst = 1'b0;
    @(negedge clk1);
    rst = 1'b1;
    idle(60);

    // continuous pushes: FIFO stays full, pushes land on pop edges
    for (int i = 0; i < 300; i++) begin
      send_valid = 1'b1;
      send_data  = 8'(i + 64);
      @(negedge clk1);
    end
    idle(48 * 5 + 20);

    // randomized traffic with occasional aborts and resets
    for (int i = 0; i < 4000; i++) begin
      send_valid = 1'($urandom_range(0, 1));
      send_data  = 8'($urandom);
      send_en    = ($urandom_range(0, 299) != 0);
      rst        = ($urandom_range(0, 599) != 0);
      @(negedge clk1);
    end
    rst = 1'b1; send_en = 1'b1;
    idle(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/communication_send_param.md
Name: communication_send_param

Overview:
Parametrised serial frame transmitter, the successor to the fixed 8-bit even-parity sender. Sends start bit, DATA_W data bits LSB-first, optional parity, and 1 or 2 stop bits on a single line `sd`. Bit time is a programmable number of clk1 cycles. A small input FIFO allows back-to-back frames with no idle gap. Sits between the board-level data source and the inter-FPGA link.

Parameters:
DATA_W, 8, data bits per frame (1..16)
PARITY, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 2, stop bits per frame (1 or 2)
CLKS_PER_BIT, 4, clk1 cycles per bit (>=1)
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)

Ports:
clk1  in  1  system clock; all logic on its rising edge
rst  in  1  reset; synchronous, active-low
send_en  in  1  transmit enable; 0 aborts the frame and flushes the FIFO
send_data  in  DATA_W  word to transmit
send_valid  in  1  send_data is valid this cycle
send_ready  out  1  FIFO can accept (= !full)
sd  out  1  serial line; idle high
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse at the end of the last stop bit
fifo_level  out  clog2(FIFO_DEPTH)+1  number of words in the FIFO

Behaviour:
- Reset (rst=0 at an edge): sd=1, busy=0, frame_done=0, FIFO empty, fifo_level=0, state IDLE, all counters 0. send_ready=0 while rst=0, and 1 from the first edge after release.
- Push: a word is written when send_valid && send_ready at an edge. Writes while full are dropped; send_ready is 0 then.
- FIFO is registered with no fall-through. A word written at edge N is visible as non-empty after N.
- FSM states are IDLE, START, DATA, PARITY, STOP. Every state except IDLE lasts CLKS_PER_BIT cycles per bit, counted by bit_cnt from 0 to CLKS_PER_BIT-1.
- IDLE: sd=1. If send_en=1 and the FIFO is non-empty, then at the next edge:
  - pop the word into the shift register;
  - compute parity = XOR of the word (even) or its complement (odd);
  - go to START.
- Latency: a word written at edge N into an empty, idle block drives sd=0 from edge N+1.
- START: sd=0, then DATA.
- DATA: sd = shift[0]. The shift register shifts right each bit, with bit_idx counting 0..DATA_W-1. Then PARITY if PARITY!=0, else STOP.
- PARITY: sd = parity bit, then STOP.
- STOP: sd=1 for STOP_BITS bits. On the last cycle of the last stop bit, frame_done=1.
  - If send_en=1 and the FIFO is non-empty, pop and go straight to START, with no idle cycle.
  - Otherwise go to IDLE.
- Frame length = (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- sd, busy and frame_done are registered outputs.
- send_en=0 at any edge:
  - state goes to IDLE, sd=1 at that edge;
  - FIFO is flushed (level 0) and counters cleared;
  - frame_done is not pulsed;
  - pushes in that cycle are dropped.
- Push and pop at the same edge: both occur, and the level is unchanged. This is allowed when full, because the pop frees a slot at the same edge; send_ready still reflects the registered full flag.
- FIFO pointers wrap modulo FIFO_DEPTH. The level is held separately so full and empty are unambiguous.
- Reset mid-frame: same as reset. The line returns high in the same cycle.

Decomposition:
- Shared package holds:
  - PARITY_NONE/EVEN/ODD constants;
  - FSM state encoding (3-bit localparams);
  - a helper giving clog2 for counter widths.
- Sub-module `send_fifo`, parametrised by width and depth. It has push/pop/flush inputs and full/empty/level outputs, plus synchronous active-low rst.
- The FSM, shift register and bit counters stay in the top module.

Test Plan:
- Defaults; reset, then push 0xA5 once. Required response:
  - sd=0 starting one cycle after the push, for 4 cycles;
  - then 1,0,1,0,0,1,0,1 at 4 cycles each;
  - parity 0, then stop 1,1;
  - frame_done pulses on cycle 48 of the frame, then busy=0.
- PARITY=2, push 0x07 -> parity bit = 0. With PARITY=1 the parity bit is 1. With PARITY=0 there is no parity slot and the frame is 44 cycles.
- Push 4 words (0x01, 0x02, 0x03, 0x04) back-to-back. Required response:
  - send_ready=0 while full, and a 5th push is dropped;
  - four contiguous frames with the start bit immediately after the last stop bit;
  - four frame_done pulses, 48 cycles apart.
- Drop send_en to 0 during the DATA bit 3 of the first frame, with 2 words queued:
  - sd=1 at the next edge, busy=0, fifo_level=0;
  - no frame_done;
  - re-enable and push 0x3C -> a clean frame follows.
- Pull rst low mid-PARITY -> the next edge gives sd=1, busy=0, fifo_level=0, send_ready=0. After release, send_ready=1.
- When full, mid-frame, push at the end-of-frame pop edge -> level stays FIFO_DEPTH, and the words are transmitted in order with none lost.
